// File: rtl/ddr_crc5_if.sv
// Byte-stream and compare signals between the DDR TX/RX path and the CRC5 block.
interface ddr_crc5_if;
  logic       i_crc_init;
  logic       i_crc_en;
  logic [7:0] i_crc_parallel_data;
  logic       i_crc_last;
  logic       i_crc_check;
  logic [4:0] i_crc_rx_crc;
  logic       o_crc_ready;
  logic [4:0] o_crc_crc_value;
  logic       o_crc_valid;
  logic       o_crc_match;
  logic       o_crc_error;

  modport master (
    output i_crc_init, i_crc_en, i_crc_parallel_data, i_crc_last,
           i_crc_check, i_crc_rx_crc,
    input  o_crc_ready, o_crc_crc_value, o_crc_valid, o_crc_match, o_crc_error
  );

  modport slave (
    input  i_crc_init, i_crc_en, i_crc_parallel_data, i_crc_last,
           i_crc_check, i_crc_rx_crc,
    output o_crc_ready, o_crc_crc_value, o_crc_valid, o_crc_match, o_crc_error
  );
endinterface

// File: rtl/ddr_crc5.sv
// Bit-serial CRC5 for DDR frames: one byte is folded in over 8 cycles, MSB first,
// with an end-of-frame valid pulse and an RX-side compare against a received CRC.
module ddr_crc5 #(
  parameter logic [4:0] SEED = 5'h1F,
  parameter logic [4:0] POLY = 5'h05
) (
  input logic       i_sys_clk,
  input logic       i_sys_rst,
  ddr_crc5_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t     state;
  state_t     state_next;
  logic [4:0] crc;
  logic [4:0] crc_shifted;
  logic [2:0] bit_cnt;
  logic [7:0] data;
  logic       last;
  logic       match;
  logic       error;
  logic       feedback;

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (bus.i_crc_en) state_next = SHIFT;
      SHIFT: begin
        if (bus.i_crc_init)     state_next = IDLE;
        else if (bit_cnt == 3'd7) state_next = last ? DONE : IDLE;
      end
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    feedback    = crc[4] ^ data[7];
    crc_shifted = {crc[3:0], 1'b0} ^ (feedback ? POLY : 5'h00);
  end

  // Init always wins over shifting; an accepted byte starts from whatever the
  // register holds after this edge, so init+en in IDLE folds the byte into SEED.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      crc     <= SEED;
      bit_cnt <= 3'd0;
      data    <= 8'h00;
      last    <= 1'b0;
      match   <= 1'b0;
      error   <= 1'b0;
    end else begin
      match <= 1'b0;
      error <= 1'b0;
      if (state == IDLE && bus.i_crc_check) begin
        match <= (crc == bus.i_crc_rx_crc);
        error <= (crc != bus.i_crc_rx_crc);
      end
      case (state)
        IDLE: begin
          if (bus.i_crc_init) crc <= SEED;
          if (bus.i_crc_en) begin
            data    <= bus.i_crc_parallel_data;
            last    <= bus.i_crc_last;
            bit_cnt <= 3'd0;
          end
        end
        SHIFT: begin
          if (bus.i_crc_init) begin
            crc <= SEED;
          end else begin
            crc     <= crc_shifted;
            data    <= {data[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        DONE: if (bus.i_crc_init) crc <= SEED;
        default: crc <= SEED;
      endcase
    end
  end

  always_comb begin
    bus.o_crc_ready     = (state == IDLE);
    bus.o_crc_valid     = (state == DONE);
    bus.o_crc_crc_value = crc;
    bus.o_crc_match     = match;
    bus.o_crc_error     = error;
  end

endmodule

// File: tb/tb_ddr_crc5.sv
// Directed and randomized frames for ddr_crc5, checked against a polynomial-division CRC model.
module tb_ddr_crc5;

  localparam logic [4:0]  SEED = 5'h1F;
  localparam logic [12:0] GEN  = 13'b0_0000_0010_0101;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  logic [4:0] model_crc;

  ddr_crc5_if bus();

  ddr_crc5 #(.SEED(5'h1F), .POLY(5'h05)) dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register after a byte = (seed * x^8 + byte * x^5) mod G, G = x^5+x^2+1.
  function automatic logic [4:0] refCrc(input logic [4:0] seed, input logic [7:0] msg);
    logic [12:0] rem;
    rem = {seed, 8'h00} ^ {msg, 5'h00};
    for (int i = 12; i >= 5; i--)
      if (rem[i]) rem = rem ^ (GEN << (i - 5));
    return rem[4:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic init, input logic en, input logic [7:0] d,
                               input logic lst, input logic chk, input logic [4:0] rx);
    bus.i_crc_init          = init;
    bus.i_crc_en            = en;
    bus.i_crc_parallel_data = d;
    bus.i_crc_last          = lst;
    bus.i_crc_check         = chk;
    bus.i_crc_rx_crc        = rx;
  endtask

  task automatic doInit();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'h00);
    model_crc = SEED;
    checkOutput("init_value", bus.o_crc_crc_value, SEED);
  endtask

  // Sends one byte; optional stray en pulses during the shift must be ignored.
  task automatic sendByte(input string tag, input logic [7:0] d, input logic lst,
                          input logic init, input logic noise);
    int ready_low;
    int valid_cnt;
    ready_low = 0;
    valid_cnt = 0;
    applyStimulus(init, 1'b1, d, lst, 1'b0, 5'h00);
    tick();
    if (init) model_crc = SEED;
    model_crc = refCrc(model_crc, d);
    for (int k = 1; k <= 8; k++) begin
      if (noise && k < 8)
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 5'h00);
      else
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'h00);
      if (!bus.o_crc_ready) ready_low++;
      if (bus.o_crc_valid) valid_cnt++;
      tick();
    end
    if (bus.o_crc_valid) valid_cnt++;
    checkOutput({tag, "_value"}, bus.o_crc_crc_value, model_crc);
    if (lst) begin
      tick();
      if (bus.o_crc_valid) valid_cnt++;
    end
    checkOutput({tag, "_ready_low"}, 8'(ready_low), 8'd8);
    checkOutput({tag, "_valid_cnt"}, 8'(valid_cnt), lst ? 8'd1 : 8'd0);
    checkOutput({tag, "_ready_after"}, bus.o_crc_ready, 8'd1);
  endtask

  task automatic doCheck(input string tag, input logic [4:0] rx, input logic init);
    logic [4:0] pre;
    pre = model_crc;
    applyStimulus(init, 1'b0, 8'h00, 1'b0, 1'b1, rx);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'h00);
    if (init) model_crc = SEED;
    checkOutput({tag, "_match"}, bus.o_crc_match, (pre == rx) ? 8'd1 : 8'd0);
    checkOutput({tag, "_error"}, bus.o_crc_error, (pre != rx) ? 8'd1 : 8'd0);
    tick();
    checkOutput({tag, "_pulse_end"}, {6'd0, bus.o_crc_match, bus.o_crc_error}, 8'd0);
  endtask

  initial begin
    int valid_cnt;
    logic [4:0] rx;
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    model_crc  = SEED;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'h00);
    #12;
    checkOutput("rst_value", bus.o_crc_crc_value, 8'h1F);
    checkOutput("rst_ready", bus.o_crc_ready, 8'd1);
    checkOutput("rst_pulses", {5'd0, bus.o_crc_valid, bus.o_crc_match, bus.o_crc_error}, 8'd0);
    #10 rst_n = 1'b1;
    tick();

    doInit();
    sendByte("b00", 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("b00_const", bus.o_crc_crc_value, 8'h0F);

    doInit();
    sendByte("bff", 8'hFF, 1'b1, 1'b0, 1'b0);
    checkOutput("bff_const", bus.o_crc_crc_value, 8'h1B);
    doCheck("chk_1b", 5'h1B, 1'b0);
    doCheck("chk_1a", 5'h1A, 1'b0);

    doInit();
    sendByte("chain0", 8'h00, 1'b0, 1'b0, 1'b0);
    sendByte("chain1", 8'hFF, 1'b1, 1'b0, 1'b0);
    checkOutput("chain_model", bus.o_crc_crc_value, {3'd0, refCrc(5'h0F, 8'hFF)});

    doInit();
    sendByte("noise", 8'h00, 1'b1, 1'b0, 1'b1);
    checkOutput("noise_const", bus.o_crc_crc_value, 8'h0F);

    // Init during the fourth shift cycle aborts the byte.
    applyStimulus(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 5'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'h00);
    repeat (3) tick();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'h00);
    model_crc = SEED;
    checkOutput("abort_value", bus.o_crc_crc_value, 8'h1F);
    checkOutput("abort_ready", bus.o_crc_ready, 8'd1);
    valid_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      if (bus.o_crc_valid) valid_cnt++;
      tick();
    end
    checkOutput("abort_no_valid", 8'(valid_cnt), 8'd0);

    // Asynchronous reset in the middle of a shift.
    applyStimulus(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 5'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'h00);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_value", bus.o_crc_crc_value, 8'h1F);
    checkOutput("arst_ready", bus.o_crc_ready, 8'd1);
    checkOutput("arst_valid", bus.o_crc_valid, 8'd0);
    #2 rst_n = 1'b1;
    model_crc = SEED;
    tick();
    checkOutput("arst_after_ready", bus.o_crc_ready, 8'd1);
    checkOutput("arst_after_value", bus.o_crc_crc_value, 8'h1F);

    sendByte("prior", 8'h5A, 1'b1, 1'b0, 1'b0);
    sendByte("init_en", 8'h00, 1'b1, 1'b1, 1'b0);
    checkOutput("init_en_const", bus.o_crc_crc_value, 8'h0F);

    doCheck("chk_with_init", 5'h0F, 1'b1);
    checkOutput("chk_with_init_value", bus.o_crc_crc_value, 8'h1F);

    for (int f = 0; f < 20; f++) begin
      if ($urandom_range(0, 1) == 1) doInit();
      sendByte("rand", 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        rx = ($urandom_range(0, 1) == 1) ? model_crc : 5'($urandom);
        doCheck("rand_chk", rx, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ddr_crc5.md
DDR_CRC5 -- requirements
Module: ddr_crc5

Interface
REQ-001: Parameter SEED, default 5'h1F, CRC register value loaded on reset and on i_crc_init.
REQ-002: Parameter POLY, default 5'h05, CRC5 generator polynomial x^5+x^2+1, with the x^5 term implicit.
REQ-003: i_sys_clk  input  1  single system clock; all state updates on its rising edge.
REQ-004: i_sys_rst  input  1  asynchronous, active-low reset.
REQ-005: i_crc_init  input  1  restart accumulation from SEED (start of DDR transaction).
REQ-006: i_crc_en  input  1  byte-valid strobe from the DDR TX/RX path.
REQ-007: i_crc_parallel_data  input  8  byte to fold into the CRC, processed MSB first.
REQ-008: i_crc_last  input  1  qualifies the accepted byte as the final data byte of the frame.
REQ-009: i_crc_check  input  1  compare request; RX side.
REQ-010: i_crc_rx_crc  input  5  CRC5 received on SDA, compared on i_crc_check.
REQ-011: o_crc_ready  output  1  block can accept a byte this cycle.
REQ-012: o_crc_crc_value  output  5  current CRC register, feeding the engine's i_crc_crc_value.
REQ-013: o_crc_valid  output  1  one-cycle pulse; o_crc_crc_value is final for the frame.
REQ-014: o_crc_match  output  1  one-cycle pulse; compared CRCs are equal.
REQ-015: o_crc_error  output  1  one-cycle pulse; compared CRCs differ.

Function
REQ-016: FSM states SHALL be IDLE, SHIFT and DONE; reset state is IDLE.
REQ-017: o_crc_ready SHALL be 1 only in IDLE.
REQ-018: A byte SHALL be accepted when i_crc_en=1 and o_crc_ready=1; on acceptance the block latches the byte and i_crc_last, clears the 3-bit bit counter and enters SHIFT.
REQ-019: i_crc_en while o_crc_ready=0 SHALL be ignored; no buffering, no error.
REQ-020: In SHIFT, each cycle SHALL process one bit d, MSB first: fb=crc[4]^d; crc <= {crc[3:0],1'b0} ^ (fb ? POLY : 5'h00).
REQ-021: SHIFT SHALL last exactly 8 cycles; byte accepted at edge N leaves o_crc_crc_value updated by edge N+8.
REQ-022: After the 8th bit, the FSM SHALL enter DONE if the latched last flag is 1, otherwise IDLE.
REQ-023: DONE SHALL last one cycle with o_crc_valid=1, then return to IDLE; o_crc_crc_value holds until the next init or byte.
REQ-024: Back-to-back bytes SHALL give 9-cycle byte spacing (1 accept + 8 shift) at most.
REQ-025: i_crc_init in IDLE or DONE SHALL load SEED at the next edge.
REQ-026: i_crc_init in SHIFT SHALL abort the byte, load SEED and return to IDLE; no o_crc_valid is produced.
REQ-027: i_crc_init and i_crc_en together in IDLE SHALL apply SEED first and then accept the byte; the result equals CRC(SEED, byte).
REQ-028: i_crc_check in IDLE SHALL compare o_crc_crc_value with i_crc_rx_crc and pulse exactly one of o_crc_match or o_crc_error for one cycle, on the following cycle.
REQ-029: i_crc_check outside IDLE SHALL be ignored.
REQ-030: i_crc_check together with i_crc_init SHALL compare against the pre-init value.

Reset
REQ-031: On i_sys_rst=0 the block SHALL, asynchronously:
- set the FSM to IDLE;
- load SEED into the CRC register (o_crc_crc_value=5'h1F);
- clear the bit counter, data latch and last flag;
- set o_crc_ready=1 and o_crc_valid=o_crc_match=o_crc_error=0.
REQ-032: Reset asserted mid-SHIFT SHALL discard the partial byte with no output pulse; after release, the first edge behaves as IDLE.

Verification
REQ-033: Reset release, init, byte 8'h00 with last=1 -> o_crc_ready low for 8 cycles, o_crc_crc_value=5'h0F, single o_crc_valid pulse on the 9th cycle after accept.
REQ-034: Init, byte 8'hFF with last=1 -> o_crc_crc_value=5'h1B with o_crc_valid; then check with i_crc_rx_crc=5'h1B -> o_crc_match pulse; check with 5'h1A -> o_crc_error pulse.
REQ-035: Init; bytes 8'h00 (last=0) then 8'hFF (last=1) back-to-back -> no valid after byte 1, 9-cycle spacing, o_crc_valid only after byte 2, value equals CRC chained from 5'h0F.
REQ-036: i_crc_en pulsed during SHIFT -> ignored; final CRC identical to REQ-033.
REQ-037: i_crc_init at shift cycle 4 -> o_crc_crc_value=5'h1F next cycle, FSM IDLE, no o_crc_valid; i_sys_rst low mid-SHIFT -> same values immediately and asynchronously.
REQ-038: i_crc_init and i_crc_en with 8'h00 in the same cycle after a prior frame -> result 5'h0F.
